ingress_unit: RTL and testbench
===============================

# ingress_unit

Synthesizable traffic source that injects packets of flits into one NoC ingress port, with a configurable injection rate. It is the transmit-side counterpart of the per-egress checker units in the NoC test harness. It stamps every head flit with the global cycle count so the egress side can measure latency, and it emits a deterministic payload pattern that the egress side can check. One instance sits on each ingress port.

## Interface
- `INGRESS_ID`, 0: value driven on `flit_out_ingress_id`.
- `N_EGRESSES`, 4: number of destinations; 1..256.
- `NUM_PACKETS`, 16: packets to send before `done`; 1..2^32-1.
- `MAX_FLITS`, 4: maximum packet length; power of two, 1..256.
- `INJECT_RATE`, 256: injection threshold in 1/256 units, 0..256; 0 never injects, 256 always injects.
- `SEED`, 16'hACE1: LFSR seed; must be non-zero.
- `INGRESS_BITS`, 64; `CYCLE_COUNT_BITS`, 64; `PAYLOAD_BITS`, 64 (fixed at 64).
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `cycle_count`  in  CYCLE_COUNT_BITS  free-running harness cycle counter.
- `enable`  in  1  permission to inject.
- `flit_out_valid`  out  1  flit offered.
- `flit_out_ready`  in  1  NoC accepts the flit; transfer occurs when valid&&ready.
- `flit_out_head` / `flit_out_tail`  out  1  first / last flit of a packet; both are set on a 1-flit packet.
- `flit_out_ingress_id`  out  INGRESS_BITS  constant `INGRESS_ID`.
- `flit_out_egress_id`  out  8  destination.
- `flit_out_payload`  out  64  see Operation.
- `packets_sent`  out  32  count of accepted tails.
- `done`  out  1  sticky; all packets sent.

## Operation
- FSM states: IDLE, GAP, SEND, DONE.
- IDLE → GAP when `enable`=1.
- GAP:
  - If `enable`=0 → IDLE.
  - Otherwise the 16-bit Galois LFSR (taps mask 16'hB400) steps once per cycle.
  - Inject when `lfsr[7:0] < INJECT_RATE`, using the pre-step value. On inject, latch `len = (lfsr[15:8] & (MAX_FLITS-1)) + 1` and `cycle_count` → SEND.
- SEND:
  - `flit_out_valid`=1; `flit_idx` starts at 0.
  - Head flit (idx 0): payload = the latched `cycle_count`.
  - Body/tail flits: payload = {`seq`[31:0], `flit_idx`[31:0]}.
  - `flit_out_egress_id` = `seq % N_EGRESSES`, constant for the whole packet.
  - `head` = (`flit_idx`==0); `tail` = (`flit_idx`==`len`-1).
  - On each handshake, `flit_idx`++.
  - On tail handshake: `seq`++ and `packets_sent`++. Then → DONE if `packets_sent`+1 == `NUM_PACKETS`; else → GAP if `enable`; else → IDLE.
- DONE: terminal until reset; `done`=1 and `flit_out_valid`=0.
- `seq` starts at 0; `packets_sent` mirrors `seq`.
- `enable` deassertion in SEND has no effect until the tail is accepted. Packets are never truncated.
- The LFSR is frozen outside GAP.

## Timing
- Reset values: `flit_out_valid`, `head`, `tail`, `egress_id`, `payload`, `packets_sent`, and `done` are all 0. `lfsr`=`SEED`; state=IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `flit_out_ready` to any output.
- Minimum `enable`→first `valid` latency is 2 cycles: IDLE→GAP, then GAP→SEND.
- Valid/ready rules:
  - Once asserted, `valid` and all flit fields hold stable until the handshake.
  - `valid` never drops without a handshake, except on reset.
- One flit is transferred per cycle while `ready`=1 in SEND.
- There is a minimum 1-cycle bubble (GAP) between packets.
- `done` rises in the cycle after the final tail handshake.
- Reset mid-packet: all outputs return to 0 asynchronously. No partial packet resumes after reset.

## Structure
- Package `ingress_pkg`:
  - State enum `ingress_state_t`.
  - `LFSR_TAPS`=16'hB400.
  - Flit struct {head, tail, ingress_id, egress_id, payload}.
- Sub-module `lfsr16`: seed, step-enable, and value out. Reused by future random-ready egress stubs.

## Test plan
- `INJECT_RATE`=256, `MAX_FLITS`=1, `NUM_PACKETS`=4, `ready`=1, `enable` from cycle 0 → 4 single-flit packets, each with head=tail=1, `egress_id` 0,1,2,3, and head payload equal to the `cycle_count` sampled in GAP. `done`=1 and `packets_sent`=4.
- `MAX_FLITS`=4 with `ready` toggling 1,0,0,1 → every flit's fields are stable while `ready`=0. Body payloads are {seq, 1}, {seq, 2}, … with no skipped or duplicated `flit_idx`.
- `INJECT_RATE`=0, `enable`=1 for 1000 cycles → `valid` is never asserted and the LFSR steps 999 times from `SEED`.
- Drop `enable` on the second flit of a 4-flit packet → the packet completes through its tail, then the FSM goes to IDLE. Re-asserting `enable` resumes with `seq`+1.
- Assert `reset` asynchronously mid-SEND → `valid` and all outputs are 0 before the next edge, and `packets_sent` is 0.
- `NUM_PACKETS`=1 with `ready` held 0 for 50 cycles → the head is held with `done`=0. After `ready`=1, `done` rises on the cycle after the tail handshake and stays high.

Source files
------------

// File: rtl/ingress_pkg.sv
// ingress_pkg: shared types and constants for the NoC ingress traffic source
package ingress_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_SEND,
    ST_DONE
  } ingress_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        head;
    logic        tail;
    logic [63:0] ingress_id;
    logic [7:0]  egress_id;
    logic [63:0] payload;
  } flit_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR that advances only when stepped
module lfsr16
  import ingress_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step,
  output logic [15:0] o_value
);
  logic [15:0] r_value;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_value <= SEED;
    else if (i_step) r_value <= {1'b0, r_value[15:1]} ^ (r_value[0] ? LFSR_TAPS : 16'd0);
  assign o_value = r_value;
endmodule

// File: rtl/ingress_unit.sv
// ingress_unit: injects LFSR-paced packets into one NoC ingress port,
// stamping head flits with the cycle count and body flits with {seq, idx}.
module ingress_unit
  import ingress_pkg::*;
#(
  parameter int unsigned INGRESS_ID       = 0,
  parameter int unsigned N_EGRESSES       = 4,
  parameter int unsigned NUM_PACKETS      = 16,
  parameter int unsigned MAX_FLITS        = 4,
  parameter int unsigned INJECT_RATE      = 256,
  parameter logic [15:0] SEED             = 16'hACE1,
  parameter int          INGRESS_BITS     = 64,
  parameter int          CYCLE_COUNT_BITS = 64,
  parameter int          PAYLOAD_BITS     = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CYCLE_COUNT_BITS-1:0] cycle_count,
  input  logic                        enable,
  output logic                        flit_out_valid,
  input  logic                        flit_out_ready,
  output logic                        flit_out_head,
  output logic                        flit_out_tail,
  output logic [INGRESS_BITS-1:0]     flit_out_ingress_id,
  output logic [7:0]                  flit_out_egress_id,
  output logic [PAYLOAD_BITS-1:0]     flit_out_payload,
  output logic [31:0]                 packets_sent,
  output logic                        done
);
  ingress_state_t r_state, w_next;
  logic [15:0] w_lfsr;
  logic [8:0]  r_len, w_len;
  logic [7:0]  r_idx;
  logic [31:0] r_seq;
  logic [63:0] r_stamp;
  logic        w_step, w_inject, w_valid, w_fire, w_last, w_final;
  flit_t       w_flit;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clock),
    .rst    (reset),
    .i_step (w_step),
    .o_value(w_lfsr)
  );

  // Injection decision and length use the LFSR value before this cycle's step
  assign w_step   = r_state == ST_GAP && enable;
  assign w_inject = w_step && ({1'b0, w_lfsr[7:0]} < 9'(INJECT_RATE));
  assign w_len    = {1'b0, w_lfsr[15:8] & 8'(MAX_FLITS - 1)} + 9'd1;
  assign w_valid  = r_state == ST_SEND;
  assign w_last   = r_idx == 8'(r_len - 9'd1);
  assign w_fire   = w_valid && flit_out_ready;
  assign w_final  = r_seq + 32'd1 == 32'(NUM_PACKETS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = enable ? ST_GAP : ST_IDLE;
      ST_GAP:  w_next = !enable ? ST_IDLE : w_inject ? ST_SEND : ST_GAP;
      ST_SEND: w_next = !(w_fire && w_last) ? ST_SEND : w_final ? ST_DONE : enable ? ST_GAP : ST_IDLE;
      default: w_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_seq   <= '0;
      r_stamp <= '0;
    end else begin
      r_state <= w_next;
      if (w_inject) begin
        r_len   <= w_len;
        r_idx   <= '0;
        r_stamp <= 64'(cycle_count);
      end else if (w_fire) r_idx <= r_idx + 8'd1;
      if (w_fire && w_last) r_seq <= r_seq + 32'd1;
    end

  // Flit fields decode from registered state only, so ready never reaches an output
  always_comb begin
    w_flit.head       = w_valid && r_idx == 8'd0;
    w_flit.tail       = w_valid && w_last;
    w_flit.ingress_id = 64'(INGRESS_ID);
    w_flit.egress_id  = w_valid ? 8'(r_seq % N_EGRESSES) : 8'd0;
    w_flit.payload    = !w_valid ? 64'd0 : r_idx == 8'd0 ? r_stamp : {r_seq, 24'd0, r_idx};
  end

  assign flit_out_valid      = w_valid;
  assign flit_out_head       = w_flit.head;
  assign flit_out_tail       = w_flit.tail;
  assign flit_out_ingress_id = INGRESS_BITS'(w_flit.ingress_id);
  assign flit_out_egress_id  = w_flit.egress_id;
  assign flit_out_payload    = PAYLOAD_BITS'(w_flit.payload);
  assign packets_sent        = r_seq;
  assign done                = r_state == ST_DONE;
endmodule

// File: tb/tb_ingress_unit.sv
// tb_ingress_unit: table, directed and randomized checks of ingress_unit against a packet-level model
module tb_ingress_unit;
  typedef struct packed {
    logic        v, h, t;
    logic [7:0]  eg;
    logic [63:0] pl;
    logic [31:0] ps;
    logic        d;
  } obs_t;

  typedef struct packed {
    logic en, rdy;
    obs_t o;
  } vec_t;

  logic clk = 0, rst = 1, en = 0, rdy = 0;
  logic [63:0] cc = 0;
  logic v[4], h[4], t[4], dn[4];
  logic [7:0] eg[4];
  logic [63:0] pl[4], iid[4];
  logic [31:0] ps[4];

  int vectors = 0, miscompares = 0;

  int p_rate[4] = '{256, 100, 0, 256};
  int p_max[4]  = '{1, 4, 4, 4};
  int p_num[4]  = '{4, 40, 16, 1};
  int p_neg[4]  = '{4, 3, 4, 4};
  logic [15:0] p_seed[4] = '{16'hACE1, 16'h1234, 16'hACE1, 16'hACE1};

  int sel, m_left, m_pos, m_seq;
  bit m_ingap, m_done;
  logic [63:0] m_stamp;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  ingress_unit #(.INJECT_RATE(256), .MAX_FLITS(1), .NUM_PACKETS(4), .N_EGRESSES(4)) d0 (
    .clock(clk), .reset(rst), .cycle_count(cc), .enable(en),
    .flit_out_valid(v[0]), .flit_out_ready(rdy), .flit_out_head(h[0]), .flit_out_tail(t[0]),
    .flit_out_ingress_id(iid[0]), .flit_out_egress_id(eg[0]), .flit_out_payload(pl[0]),
    .packets_sent(ps[0]), .done(dn[0]));

  ingress_unit #(.INGRESS_ID(5), .INJECT_RATE(100), .MAX_FLITS(4), .NUM_PACKETS(40),
                 .N_EGRESSES(3), .SEED(16'h1234)) d1 (
    .clock(clk), .reset(rst), .cycle_count(cc), .enable(en),
    .flit_out_valid(v[1]), .flit_out_ready(rdy), .flit_out_head(h[1]), .flit_out_tail(t[1]),
    .flit_out_ingress_id(iid[1]), .flit_out_egress_id(eg[1]), .flit_out_payload(pl[1]),
    .packets_sent(ps[1]), .done(dn[1]));

  ingress_unit #(.INJECT_RATE(0)) d2 (
    .clock(clk), .reset(rst), .cycle_count(cc), .enable(en),
    .flit_out_valid(v[2]), .flit_out_ready(rdy), .flit_out_head(h[2]), .flit_out_tail(t[2]),
    .flit_out_ingress_id(iid[2]), .flit_out_egress_id(eg[2]), .flit_out_payload(pl[2]),
    .packets_sent(ps[2]), .done(dn[2]));

  ingress_unit #(.INJECT_RATE(256), .MAX_FLITS(4), .NUM_PACKETS(1)) d3 (
    .clock(clk), .reset(rst), .cycle_count(cc), .enable(en),
    .flit_out_valid(v[3]), .flit_out_ready(rdy), .flit_out_head(h[3]), .flit_out_tail(t[3]),
    .flit_out_ingress_id(iid[3]), .flit_out_egress_id(eg[3]), .flit_out_payload(pl[3]),
    .packets_sent(ps[3]), .done(dn[3]));

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic obs_t observe(int s);
    return '{v[s], h[s], t[s], eg[s], pl[s], ps[s], dn[s]};
  endfunction

  // Packet-level model: remaining flits of the current packet, position within it, sent count
  function automatic obs_t expected();
    obs_t e;
    e.v  = m_left > 0;
    e.h  = e.v && m_pos == 0;
    e.t  = e.v && m_left == 1;
    e.eg = e.v ? 8'(m_seq % p_neg[sel]) : 8'd0;
    e.pl = !e.v ? 64'd0 : m_pos == 0 ? m_stamp : {32'(m_seq), 32'(m_pos)};
    e.ps = 32'(m_seq);
    e.d  = m_done;
    return e;
  endfunction

  function automatic vec_t mkv(logic ve, vh, vt, logic [7:0] veg, logic [63:0] vpl, logic [31:0] vps, logic vd);
    return '{1'b1, 1'b1, '{ve, vh, vt, veg, vpl, vps, vd}};
  endfunction

  task automatic model_reset(int s);
    sel = s; m_left = 0; m_pos = 0; m_seq = 0; m_ingap = 0; m_done = 0;
    m_stamp = 0; m_lfsr = p_seed[s];
  endtask

  task automatic model_step();
    if (m_done) return;
    if (m_left > 0) begin
      if (rdy) begin
        m_pos++;
        m_left--;
        if (m_left == 0) begin
          m_seq++;
          if (m_seq == p_num[sel]) m_done = 1;
          else m_ingap = en;
        end
      end
    end else if (m_ingap) begin
      if (!en) m_ingap = 0;
      else begin
        if (int'(m_lfsr[7:0]) < p_rate[sel]) begin
          m_left  = int'(m_lfsr[15:8]) % p_max[sel] + 1;
          m_pos   = 0;
          m_stamp = cc;
          m_ingap = 0;
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
    end else m_ingap = en;
  endtask

  task automatic cmp_obs(string nm, obs_t g, obs_t w);
    vectors++;
    if (g !== w) begin
      miscompares++;
      $display("FAIL %s: got v%b h%b t%b eg%0d pl%h ps%0d done%b, want v%b h%b t%b eg%0d pl%h ps%0d done%b",
               nm, g.v, g.h, g.t, g.eg, g.pl, g.ps, g.d, w.v, w.h, w.t, w.eg, w.pl, w.ps, w.d);
    end
  endtask

  task automatic expect_eq(string nm, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic cycle(string nm);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_obs(nm, observe(sel), expected());
    cc = cc + 64'd1;
  endtask

  task automatic do_reset(int s);
    rst = 1; en = 0; rdy = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset(s);
    cmp_obs("reset", observe(s), expected());
  endtask

  task automatic find_multi(output bit ok);
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++)
      if (v[1] && h[1] && !t[1]) ok = 1;
      else cycle("search");
  endtask

  initial begin
    vec_t tbl[10];
    logic [3:0] pat;
    logic [15:0] e;
    bit ok, seen;
    int s0, n;

    // Single-flit packets every other cycle; cycle_count before edge k is 100+k
    tbl[0] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd0, 0);
    tbl[1] = mkv(1, 1, 1, 8'd0, 64'd102, 32'd0, 0);
    tbl[2] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd1, 0);
    tbl[3] = mkv(1, 1, 1, 8'd1, 64'd104, 32'd1, 0);
    tbl[4] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd2, 0);
    tbl[5] = mkv(1, 1, 1, 8'd2, 64'd106, 32'd2, 0);
    tbl[6] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd3, 0);
    tbl[7] = mkv(1, 1, 1, 8'd3, 64'd108, 32'd3, 0);
    tbl[8] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd4, 1);
    tbl[9] = mkv(0, 0, 0, 8'd0, 64'd0,   32'd4, 1);

    do_reset(0);
    for (int k = 0; k < 10; k++) begin
      en = tbl[k].en; rdy = tbl[k].rdy; cc = 64'(101 + k);
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp_obs($sformatf("tbl%0d", k + 1), observe(0), tbl[k].o);
    end

    do_reset(2);
    en = 1; rdy = 1; seen = 0;
    repeat (1000) begin
      cycle("rate0");
      seen |= v[2];
    end
    expect_eq("rate0_never_valid", 64'(seen), 64'd0);
    e = 16'hACE1;
    repeat (999) e = lfsr_next(e);
    expect_eq("rate0_lfsr_999_steps", 64'(d2.u_lfsr.o_value), 64'(e));

    do_reset(1);
    pat = 4'b1001;
    en = 1;
    for (int i = 0; i < 400; i++) begin
      rdy = pat[i % 4];
      cycle("ready_1001");
    end

    do_reset(1);
    en = 1; rdy = 1;
    find_multi(ok);
    expect_eq("drop_find_packet", 64'(ok), 64'd1);
    s0 = int'(ps[1]);
    cycle("drop_head");
    en = 0;
    repeat (10) cycle("drop_drain");
    expect_eq("drop_idle_valid", 64'(v[1]), 64'd0);
    expect_eq("drop_count", 64'(ps[1]), 64'(s0 + 1));
    en = 1;
    n = 0;
    while (!v[1] && n < 200) begin
      cycle("drop_resume");
      n++;
    end
    expect_eq("drop_resume_egress", 64'(eg[1]), 64'((s0 + 1) % 3));

    find_multi(ok);
    expect_eq("areset_find_packet", 64'(ok), 64'd1);
    cycle("areset_head");
    #1 rst = 1;
    #1 cmp_obs("areset_outputs_zero", observe(1), '0);
    @(negedge clk);
    rst = 0;
    model_reset(1);
    cmp_obs("areset_after", observe(1), expected());
    repeat (20) cycle("areset_restart");

    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      en  = $urandom_range(0, 9) != 0;
      rdy = $urandom_range(0, 2) != 0;
      cycle("random");
    end
    expect_eq("random_done", 64'(dn[1]), 64'd1);
    expect_eq("random_packets_sent", 64'(ps[1]), 64'd40);
    expect_eq("ingress_id", iid[1], 64'd5);

    do_reset(3);
    en = 1; rdy = 0;
    n = 0;
    while (!v[3] && n < 20) begin
      cycle("hold_wait");
      n++;
    end
    repeat (50) cycle("hold_stall");
    expect_eq("hold_head_no_done", 64'({v[3], h[3], dn[3]}), 64'd6);
    rdy = 1;
    n = 0;
    while (!dn[3] && n < 20) begin
      cycle("hold_drain");
      n++;
    end
    expect_eq("hold_done", 64'(dn[3]), 64'd1);
    expect_eq("hold_count", 64'(ps[3]), 64'd1);
    en = 0; rdy = 0;
    repeat (5) cycle("hold_sticky");
    expect_eq("hold_done_sticky", 64'(dn[3]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
